// File: rtl/lz77_sched_pkg.sv
// Shared types and defaults for the LZ77 encoder scheduler.
package lz77_sched_pkg;

    localparam int NUM_CH_DEF     = 2;
    localparam int LOAD_LEN_DEF   = 2049;
    localparam int ADDR_W_DEF     = 12;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 16384;

    // Channel tag width inside a stored result; wide enough for any practical NUM_CH.
    localparam int CH_MAX_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PARK  = 3'd1,
        S_GAP   = 3'd2,
        S_ARM   = 3'd3,
        S_LOAD  = 3'd4,
        S_RUN   = 3'd5,
        S_DRAIN = 3'd6
    } sched_state_e;

    typedef struct packed {
        logic [CH_MAX_W-1:0] ch;
        logic [3:0]          offset;
        logic [2:0]          len;
        logic [7:0]          chr;
        logic                last;
    } result_t;

    // Return a copy of a result with its last flag set.
    function automatic result_t mark_last(input result_t r);
        result_t t;
        t      = r;
        t.last = 1'b1;
        return t;
    endfunction

endpackage

// File: rtl/lz77_result_fifo.sv
// Synchronous result FIFO; a push while full (and not popping) is dropped and flagged.
module lz77_result_fifo
    import lz77_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push_i,
    input  result_t push_data_i,
    input  logic    pop_i,
    output result_t head_o,
    output logic    empty_o,
    output logic    full_o,
    output logic    drop_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    result_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop_s  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign drop_o    = push_i && !do_push_s;
    assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];

    // Occupancy update from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Store accepted results at the write pointer.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lz77_enc_scheduler.sv
// Round-robin scheduler sharing one LZ77 encoder between NUM_CH channels.
module lz77_enc_scheduler
    import lz77_sched_pkg::*;
#(
    parameter  int NUM_CH     = NUM_CH_DEF,
    parameter  int LOAD_LEN   = LOAD_LEN_DEF,
    parameter  int ADDR_W     = ADDR_W_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter  int TIMEOUT    = TIMEOUT_DEF,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     req_i,
    output logic [NUM_CH-1:0]     gnt_o,
    output logic [NUM_CH-1:0]     done_o,
    output logic                  err_o,
    output logic                  ovf_o,
    output logic [ADDR_W-1:0]     rd_addr_o,
    input  logic [NUM_CH*8-1:0]   rd_data_i,
    output logic                  enc_rst_o,
    output logic [7:0]            enc_chardata_o,
    input  logic                  enc_valid_i,
    input  logic                  enc_finish_i,
    input  logic [3:0]            enc_offset_i,
    input  logic [2:0]            enc_match_len_i,
    input  logic [7:0]            enc_char_nxt_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [CH_W-1:0]       out_ch_o,
    output logic [3:0]            out_offset_o,
    output logic [2:0]            out_len_o,
    output logic [7:0]            out_char_o,
    output logic                  out_last_o
);
    localparam int CNT_MAX = (LOAD_LEN > TIMEOUT) ? LOAD_LEN : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(LOAD_LEN - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LOAD_LEN - 1);

    sched_state_e      state_q, state_d;
    logic [CH_W-1:0]   gidx_q, gidx_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic              err_q, err_d;
    logic              ovf_q;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              enc_rst_q, enc_rst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stg_valid_q, stg_valid_d;
    result_t           stg_q, stg_d;
    logic              fin_pend_q, fin_pend_d;
    logic              tmo_q, tmo_d;

    logic              pick_found_s;
    logic [CH_W-1:0]   pick_idx_s;
    logic [7:0]        sel_byte_s;
    result_t           new_trip_s;
    logic              push_s;
    result_t           push_data_s;
    logic              pop_s;
    result_t           head_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              drop_s;

    // Round-robin pick: first requester strictly after the last-granted channel.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (!pick_found_s && req_i[j] && (j == (int'(last_q) + i) % NUM_CH)) begin
                    pick_found_s = 1'b1;
                    pick_idx_s   = CH_W'(j);
                end else begin
                    pick_found_s = pick_found_s;
                end
            end
        end
    end

    // Byte lane of the granted channel; the encoder only sees it during LOAD.
    always_comb begin
        sel_byte_s = 8'h00;
        for (int j = 0; j < NUM_CH; j++) begin
            if (gidx_q == CH_W'(j)) begin
                sel_byte_s = rd_data_i[j*8 +: 8];
            end else begin
                sel_byte_s = sel_byte_s;
            end
        end
        if (state_q == S_LOAD) begin
            enc_chardata_o = sel_byte_s;
        end else begin
            enc_chardata_o = 8'h00;
        end
    end

    assign new_trip_s = '{ch:     CH_MAX_W'(gidx_q),
                          offset: enc_offset_i,
                          len:    enc_match_len_i,
                          chr:    enc_char_nxt_i,
                          last:   1'b0};

    // Job sequencer: next state, staging/push decisions and registered outputs.
    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = 1'b0;
        rd_addr_d   = rd_addr_q;
        cnt_d       = cnt_q;
        stg_valid_d = stg_valid_q;
        stg_d       = stg_q;
        fin_pend_d  = fin_pend_q;
        tmo_d       = tmo_q;
        push_s      = 1'b0;
        push_data_s = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    state_d     = S_PARK;
                    gidx_d      = pick_idx_s;
                    last_d      = pick_idx_s;
                    gnt_d       = NUM_CH'(1'b1) << pick_idx_s;
                    stg_valid_d = 1'b0;
                    fin_pend_d  = 1'b0;
                    tmo_d       = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PARK: state_d = S_GAP;
            S_GAP: begin
                state_d   = S_ARM;
                rd_addr_d = '0;
            end
            S_ARM: begin
                state_d   = S_LOAD;
                cnt_d     = '0;
                rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
            S_LOAD: begin
                // Address runs one ahead of the byte being consumed, parking on the last one.
                if (rd_addr_q == ADDR_LAST) begin
                    rd_addr_d = rd_addr_q;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
                if (cnt_q == LOAD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (cnt_q == TMO_LAST) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A fresh triple always takes priority; finish or timeout closes out next cycle.
                if (enc_valid_i) begin
                    push_s      = stg_valid_q;
                    push_data_s = stg_q;
                    stg_d       = new_trip_s;
                    stg_valid_d = 1'b1;
                    fin_pend_d  = fin_pend_q | enc_finish_i;
                end else if (fin_pend_q || enc_finish_i || (cnt_q == TMO_LAST)) begin
                    push_s      = stg_valid_q;
                    push_data_s = mark_last(stg_q);
                    stg_valid_d = 1'b0;
                    fin_pend_d  = 1'b0;
                    tmo_d       = !(fin_pend_q || enc_finish_i);
                    state_d     = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty_s) begin
                    done_d  = gnt_q;
                    err_d   = tmo_q;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        enc_rst_d = (state_d == S_PARK) || (state_d == S_ARM);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gidx_q      <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            rd_addr_q   <= '0;
            enc_rst_q   <= 1'b0;
            cnt_q       <= '0;
            stg_valid_q <= 1'b0;
            stg_q       <= '0;
            fin_pend_q  <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovf_q       <= ovf_q | drop_s;
            rd_addr_q   <= rd_addr_d;
            enc_rst_q   <= enc_rst_d;
            cnt_q       <= cnt_d;
            stg_valid_q <= stg_valid_d;
            stg_q       <= stg_d;
            fin_pend_q  <= fin_pend_d;
            tmo_q       <= tmo_d;
        end
    end

    lz77_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s),
        .drop_o      (drop_s)
    );

    assign pop_s        = out_valid_o && out_ready_i;
    assign out_valid_o  = !fifo_empty_s;
    assign out_ch_o     = head_s.ch[CH_W-1:0];
    assign out_offset_o = head_s.offset;
    assign out_len_o    = head_s.len;
    assign out_char_o   = head_s.chr;
    assign out_last_o   = head_s.last;

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign ovf_o     = ovf_q;
    assign rd_addr_o = rd_addr_q;
    assign enc_rst_o = enc_rst_q;

endmodule

// File: tb/tb_lz77_enc_scheduler.sv
// Scoreboard bench for lz77_enc_scheduler with a stub encoder and channel buffer model.
module tb_lz77_enc_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic        ovf;
    logic [11:0] rd_addr;
    logic [15:0] rd_data;
    logic        enc_rst;
    logic [7:0]  enc_chardata;
    logic        enc_valid;
    logic        enc_finish;
    logic [3:0]  enc_offset;
    logic [2:0]  enc_match_len;
    logic [7:0]  enc_char_nxt;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_ch;
    logic [3:0]  out_offset;
    logic [2:0]  out_len;
    logic [7:0]  out_char;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q [$];
    logic        stalled = 1'b0;
    logic [23:0] prev_out;
    logic [23:0] cur_out;
    logic [23:0] exp_out;

    // Hand-chosen encoder triples; entries 0 and 1 are (8,0,'a') and (0,2,'b').
    logic [3:0] t_off [6] = '{4'd8, 4'd0, 4'd3, 4'd1, 4'd15, 4'd2};
    logic [2:0] t_len [6] = '{3'd0, 3'd2, 3'd1, 3'd4, 3'd7, 3'd3};
    logic [7:0] t_chr [6] = '{8'h61, 8'h62, 8'h63, 8'h41, 8'h7E, 8'h00};

    lz77_enc_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .req_i           (req),
        .gnt_o           (gnt),
        .done_o          (done),
        .err_o           (err),
        .ovf_o           (ovf),
        .rd_addr_o       (rd_addr),
        .rd_data_i       (rd_data),
        .enc_rst_o       (enc_rst),
        .enc_chardata_o  (enc_chardata),
        .enc_valid_i     (enc_valid),
        .enc_finish_i    (enc_finish),
        .enc_offset_i    (enc_offset),
        .enc_match_len_i (enc_match_len),
        .enc_char_nxt_i  (enc_char_nxt),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_ch_o        (out_ch),
        .out_offset_o    (out_offset),
        .out_len_o       (out_len),
        .out_char_o      (out_char),
        .out_last_o      (out_last)
    );

    always #5 clk = ~clk;

    // Buffer content: address-derived bytes, different per channel.
    function automatic logic [7:0] buf_byte(input logic [11:0] a, input int ch);
        logic [7:0] k;
        k = (ch == 1) ? 8'h3C : 8'hC3;
        return a[7:0] ^ {a[11:8], a[11:8]} ^ k;
    endfunction

    // Channel buffer read port with one cycle of latency.
    always @(posedge clk) begin
        rd_data <= {buf_byte(rd_addr, 1), buf_byte(rd_addr, 0)};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on every accepted beat and checks stall stability.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            cur_out = {7'd0, out_ch, out_offset, out_len, out_char, out_last};
            if (stalled) begin
                chk("out_stable", {7'd0, out_valid, cur_out}, {7'd0, 1'b1, prev_out});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected actual=%0h expected=none", cur_out);
                end else begin
                    exp_out = exp_q.pop_front();
                    chk("out_triple", cur_out, exp_out);
                end
            end
            stalled  = out_valid && !out_ready;
            prev_out = cur_out;
        end
    end

    // mode 0: finish after the triples, 1: finish with the last triple, 2: never finish.
    task automatic run_job(input logic [1:0] req_v, input int exp_ch, input int n,
                           input int mode, input bit hold_ready, input bit exp_err,
                           input bit keep_req);
        int waited;
        int nbad;
        int limit;
        req    = req_v;
        waited = 0;
        while (gnt == 2'b00 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("gnt", 32'(gnt), 32'(2'b01 << exp_ch));
        if (!keep_req) req = 2'b00;
        if (hold_ready) chk("ovf_before", 32'(ovf), 32'd0);
        chk("enc_rst_park", 32'(enc_rst), 32'd1);
        @(negedge clk);
        chk("enc_rst_gap", 32'(enc_rst), 32'd0);
        @(negedge clk);
        chk("enc_rst_arm", 32'(enc_rst), 32'd1);
        chk("rd_addr_arm", 32'(rd_addr), 32'd0);
        nbad = 0;
        for (int k = 0; k < 2049; k++) begin
            @(negedge clk);
            if (enc_chardata !== buf_byte(12'(k), exp_ch) || enc_rst !== 1'b0) nbad++;
        end
        chk("load_bytes_bad", 32'(nbad), 32'd0);
        @(negedge clk);
        chk("run_chardata_zero", 32'(enc_chardata), 32'd0);
        chk("rd_addr_stop", 32'(rd_addr), 32'd2048);
        if (hold_ready) out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            enc_valid     = 1'b1;
            enc_offset    = t_off[i];
            enc_match_len = t_len[i];
            enc_char_nxt  = t_chr[i];
            enc_finish    = (mode == 1) && (i == n - 1);
            if (!hold_ready || i < 4) begin
                exp_q.push_back({8'(exp_ch), t_off[i], t_len[i], t_chr[i], (i == n - 1)});
            end
            @(negedge clk);
        end
        enc_valid  = 1'b0;
        enc_finish = 1'b0;
        if (mode == 0) begin
            enc_finish = 1'b1;
            @(negedge clk);
            enc_finish = 1'b0;
        end
        if (hold_ready) begin
            repeat (4) @(negedge clk);
            chk("ovf_set", 32'(ovf), 32'd1);
            chk("no_done_while_full", 32'(done), 32'd0);
            out_ready = 1'b1;
        end
        limit  = (mode == 2) ? 20000 : 100;
        waited = 0;
        while (done == 2'b00 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (mode == 2) chk("timeout_late", 32'(waited > 16000), 32'd1);
        chk("done", 32'(done), 32'(2'b01 << exp_ch));
        chk("err", 32'(err), 32'(exp_err));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("done_pulse_end", 32'({done, err}), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int waited;
        reset         = 1'b1;
        req           = 2'b00;
        enc_valid     = 1'b0;
        enc_finish    = 1'b0;
        enc_offset    = 4'd0;
        enc_match_len = 3'd0;
        enc_char_nxt  = 8'd0;
        out_ready     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({gnt, done, err, ovf, enc_rst}), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_chardata", 32'(enc_chardata), 32'd0);
        chk("rst_out", {7'd0, out_valid, out_ch, out_offset, out_len, out_char, out_last}, 32'd0);
        reset = 1'b0;

        // Basic job on channel 0.
        run_job(2'b01, 0, 2, 0, 1'b0, 1'b0, 1'b0);

        // Round robin with both channels requesting from reset.
        apply_reset();
        run_job(2'b11, 0, 3, 0, 1'b0, 1'b0, 1'b1);
        run_job(2'b11, 1, 2, 0, 1'b0, 1'b0, 1'b1);
        run_job(2'b11, 0, 1, 0, 1'b0, 1'b0, 1'b0);

        // Final triple with finish in the same cycle.
        run_job(2'b10, 1, 3, 1, 1'b0, 1'b0, 1'b0);

        // Overflow with out_ready held low.
        run_job(2'b01, 0, 5, 0, 1'b1, 1'b0, 1'b0);

        // Encoder never finishes.
        run_job(2'b10, 1, 2, 2, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of LOAD.
        req    = 2'b10;
        waited = 0;
        while (gnt == 2'b00 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("gnt_pre_reset", 32'(gnt), 32'd2);
        repeat (100) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_ctrl", 32'({gnt, done, err, ovf, enc_rst}), 32'd0);
        chk("midrst_rd_addr", 32'(rd_addr), 32'd0);
        chk("midrst_chardata", 32'(enc_chardata), 32'd0);
        chk("midrst_out", {7'd0, out_valid, out_ch, out_offset, out_len, out_char, out_last}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_job(2'b11, 0, 2, 0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lz77_enc_scheduler.md
# lz77_enc_scheduler

Shares one LZ77 encoder (9-byte search window, 4-bit offset, 3-bit match length, 8-bit next char) between NUM_CH requesting channels. Grants one channel per job by round-robin, sequences the encoder's arm/load/encode phases, and streams that channel's buffer into it from a 1-cycle-latency read port. Collects the emitted triples into a tagged, backpressured result stream. Sits between the channel buffer memories and the downstream packer.

## Interface
- NUM_CH, 2, number of requesting channels (CH_W = clog2(NUM_CH), min 1)
- LOAD_LEN, 2049, bytes streamed into the encoder per job
- ADDR_W, 12, read address width
- FIFO_DEPTH, 4, result FIFO entries (power of 2)
- TIMEOUT, 16384, max RUN cycles before a job is aborted

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  NUM_CH  job request per channel, level
- gnt  out  NUM_CH  one-hot grant, held PARK through DRAIN
- done  out  NUM_CH  1-cycle completion pulse to the granted channel
- err  out  1  1-cycle pulse with done when the job timed out
- ovf  out  1  sticky: result dropped on a full FIFO; cleared only by reset
- rd_addr  out  ADDR_W  buffer read address, shared by all channels
- rd_data  in  NUM_CH*8  per-channel read data, valid 1 cycle after rd_addr
- enc_rst  out  1  encoder arm/park pulse
- enc_chardata  out  8  byte to encoder
- enc_valid, enc_finish  in  1 each  encoder triple strobe / job complete
- enc_offset  in  4;  enc_match_len  in  3;  enc_char_nxt  in  8  encoder triple
- out_valid  out  1;  out_ready  in  1  result handshake
- out_ch  out  CH_W;  out_offset  out  4;  out_len  out  3;  out_char  out  8;  out_last  out  1  result fields

## Operation
- States: IDLE, PARK, GAP, ARM, LOAD, RUN, DRAIN.
- IDLE: if any req, pick the first requester after the last-granted channel (wrapping) and go to PARK with gnt registered. After reset the last-granted pointer is NUM_CH-1, so channel 0 wins first.
- PARK: enc_rst=1 for 1 cycle, forcing the encoder idle. GAP: enc_rst=0 for 1 cycle. ARM: enc_rst=1 for 1 cycle, rd_addr=0.
- LOAD: exactly LOAD_LEN cycles. enc_chardata = rd_data byte of the granted channel. rd_addr advances by 1 per cycle and stops at LOAD_LEN-1. Outside LOAD, enc_chardata=0.
- RUN: on each enc_valid, the triple {gnt index, offset, len, char} is written to the staging register. Any previously staged triple is pushed to the FIFO with last=0.
- On enc_finish in a cycle without enc_valid:
  - the staged triple, if any, is pushed with last=1;
  - state goes to DRAIN.
  - If enc_valid and enc_finish are asserted together, the triple is handled first and the finish is latched and honoured the next cycle.
- Zero triples then finish: nothing is pushed.
- Timeout: a RUN counter reaching TIMEOUT aborts to DRAIN. The staged triple is pushed with last=1 and an err flag is latched.
- Push to a full FIFO: the entry is dropped and ovf is set. A simultaneous pop and push on a full FIFO is not an overflow.
- DRAIN: wait for the FIFO to empty. Then done[granted]=1 (and err=1 if timed out) for 1 cycle, gnt drops, go to IDLE.
- req changes during a job are ignored. A job always runs to DRAIN.
- reset at any time: every state and output returns to its reset value, the FIFO is emptied, the staging register is cleared, and ovf is cleared.

## Timing
- Reset values: gnt=0, done=0, err=0, ovf=0, rd_addr=0, enc_rst=0, enc_chardata=0, out_valid=0, all out_* fields=0. State is IDLE.
- req seen in IDLE at cycle t gives gnt at t+1, PARK at t+1, GAP at t+2, ARM at t+3, first LOAD byte at t+4, RUN at t+4+LOAD_LEN.
- Output side is a standard valid/ready handshake. out_* are stable while out_valid=1 and out_ready=0. FIFO-to-output latency is 1 cycle after push.
- The encoder cannot stall. Only ovf reports loss.

## Structure
- Package lz77_sched_pkg: state enum, result struct {ch, offset[3:0], len[2:0], char[7:0], last}, default parameter constants.
- One sub-module, lz77_result_fifo: synchronous FIFO of result structs with full/empty flags and push-on-full drop, async reset.

## Test plan
- req=2'b01, stub encoder emits triples (8,0,0x61), (0,2,0x62) then finish:
  - enc_rst pattern is 1,0,1;
  - exactly 2049 bytes are loaded, addr 0..2048, aligned;
  - outputs are ch=0 (8,0,0x61,last=0), then (0,2,0x62,last=1);
  - done=2'b01 for 1 cycle.
- req=2'b11 held for 3 jobs: grants go 0,1,0 and each done goes to the matching channel.
- enc_valid and enc_finish asserted in the same cycle: the final triple is delivered with last=1 and nothing is lost.
- out_ready=0 with 5 triples emitted, FIFO_DEPTH=4:
  - ovf=1 and exactly 4 entries are delivered once out_ready=1;
  - done follows the last pop.
- Stub never asserts finish: at TIMEOUT the staged triple comes out with last=1, then done and err pulse together.
- reset asserted mid-LOAD: all outputs return to reset values immediately, and a new req restarts with PARK.
